// File: rtl/push_btn_bank_pkg.sv
// Shared constants and types for the push-button bank: opcode encodings,
// instruction field positions and the controller state enum.
package push_btn_bank_pkg;

  localparam int unsigned OPC_MSB   = 11;
  localparam int unsigned OPC_LSB   = 8;
  localparam int unsigned IMM_WIDTH = 8;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] RDA = 4'h1;
  localparam logic [3:0] RDC = 4'h2;
  localparam logic [3:0] CLR = 4'h3;
  localparam logic [3:0] MSK = 4'h4;

  typedef enum logic [0:0] {
    READY = 1'b0,
    ERROR = 1'b1
  } state_e;

endpackage

// File: rtl/push_btn_bank_n_if.sv
// Instruction/result bus between the controller (master) and the button bank (slave).
interface push_btn_bank_n_if #(
  parameter int unsigned NumBtns = 8
);
  logic [11:0]        inst;
  logic               inst_en;
  logic [NumBtns-1:0] btn_state;
  logic               error;

  modport master (
    output inst,
    output inst_en,
    input  btn_state,
    input  error
  );

  modport slave (
    input  inst,
    input  inst_en,
    output btn_state,
    output error
  );
endinterface

// File: rtl/btn_debounce.sv
// Single-channel synchroniser + debouncer; rise pulses for one cycle on the
// edge where the stable level is accepted as 1.
module btn_debounce #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);

  logic [1:0]          sync_q;
  logic                stable_q;
  logic                rise_q;
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise_q <= 1'b0;
      if (sync_q[1] != stable_q) begin
        // The DebounceCycles-th consecutive differing cycle accepts the new level.
        if (cnt_q == CntWidth'(DebounceCycles - 1)) begin
          stable_q <= sync_q[1];
          rise_q   <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/push_btn_bank_n.sv
// Debounced push-button bank with sticky press flags, enable mask and an
// instruction-driven read/clear interface; undefined instructions lock into ERROR.
module push_btn_bank_n
  import push_btn_bank_pkg::*;
#(
  parameter int unsigned NumBtns        = 8,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NumBtns-1:0] btn,
  push_btn_bank_n_if.slave   bus
);

  logic [NumBtns-1:0] stable;
  logic [NumBtns-1:0] rise;

  for (genvar g = 0; g < NumBtns; g++) begin : g_db
    btn_debounce #(
      .DebounceCycles(DebounceCycles)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn[g]),
      .stable(stable[g]),
      .rise  (rise[g])
    );
  end

  state_e               state_q;
  logic [NumBtns-1:0]   flag_q, flag_d;
  logic [NumBtns-1:0]   mask_q, mask_d;
  logic [NumBtns-1:0]   btn_state_q;
  logic                 error_q;

  logic [3:0]           opc;
  logic [IMM_WIDTH-1:0] imm;
  logic                 exec;
  logic                 bad;
  logic                 rd_load;
  logic [NumBtns-1:0]   rd_val;
  logic [NumBtns-1:0]   flag_clr;
  logic [NumBtns-1:0]   press;

  assign opc   = bus.inst[OPC_MSB:OPC_LSB];
  assign imm   = bus.inst[IMM_WIDTH-1:0];
  assign exec  = bus.inst_en && (state_q == READY);
  assign press = rise & stable & mask_q;

  always_comb begin
    bad      = 1'b0;
    rd_load  = 1'b0;
    rd_val   = '0;
    flag_clr = '0;
    mask_d   = mask_q;
    if (exec) begin
      unique case (opc)
        NOP: ;
        RDA: begin
          rd_load  = 1'b1;
          rd_val   = flag_q;
          flag_clr = '1;
        end
        RDC: begin
          if (imm >= IMM_WIDTH'(NumBtns)) begin
            bad = 1'b1;
          end else begin
            rd_load = 1'b1;
            for (int unsigned i = 0; i < NumBtns; i++) begin
              if (imm == IMM_WIDTH'(i)) begin
                rd_val[i]   = flag_q[i];
                flag_clr[i] = 1'b1;
              end
            end
          end
        end
        CLR: flag_clr = '1;
        MSK: mask_d = imm[NumBtns-1:0];
        default: bad = 1'b1;
      endcase
    end
    // A press landing on a clearing edge wins so the event is never lost.
    flag_d = (flag_q & ~flag_clr) | press;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= READY;
      error_q     <= 1'b0;
      btn_state_q <= '0;
      flag_q      <= '0;
      mask_q      <= '1;
    end else begin
      flag_q <= flag_d;
      mask_q <= mask_d;
      if (rd_load) begin
        btn_state_q <= rd_val;
      end
      if (bad) begin
        state_q <= ERROR;
        error_q <= 1'b1;
      end
    end
  end

  assign bus.btn_state = btn_state_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_push_btn_bank_n.sv
// Directed bench for push_btn_bank_n with NumBtns=4, DebounceCycles=4.
module tb_push_btn_bank_n;
  import push_btn_bank_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] btn;
  int         checks;
  int         errors;

  push_btn_bank_n_if #(.NumBtns(4)) bus ();

  push_btn_bank_n #(
    .NumBtns       (4),
    .DebounceCycles(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn  (btn),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] imm);
    bus.inst    = {op, imm};
    bus.inst_en = 1'b1;
    tick(1);
    bus.inst_en = 1'b0;
    bus.inst    = 12'h000;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
    checks++;
    assert (bus.error === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.error, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    btn         = 4'b0000;
    bus.inst    = 12'h000;
    bus.inst_en = 1'b0;
    #2 reset = 1'b0;
    tick(2);
    chk("reset_state", bus.btn_state, 4'b0000);
    chk_err("reset_error", 1'b0);
    reset = 1'b1;
    tick(2);

    // Idle reads with no buttons
    exec(RDA, 8'h00);
    chk("idle_rda", bus.btn_state, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      exec(RDC, 8'(c));
      chk("idle_rdc", bus.btn_state, 4'b0000);
    end
    exec(CLR, 8'h00);
    exec(NOP, 8'h00);
    chk("idle_clr_nop", bus.btn_state, 4'b0000);
    chk_err("idle_error", 1'b0);

    // Bouncy press on btn[1]
    btn = 4'b0010; tick(1);
    btn = 4'b0000; tick(1);
    btn = 4'b0010; tick(10);
    exec(RDA, 8'h00);
    chk("bounce_rda", bus.btn_state, 4'b0010);
    exec(RDA, 8'h00);
    chk("bounce_rda2", bus.btn_state, 4'b0000);
    btn = 4'b0000; tick(10);

    // 3-cycle pulse must be rejected
    btn = 4'b0010; tick(3);
    btn = 4'b0000; tick(10);
    exec(RDA, 8'h00);
    chk("short_pulse", bus.btn_state, 4'b0000);

    // Two presses before one read give a single sticky flag
    btn = 4'b0001; tick(8);
    btn = 4'b0000; tick(8);
    btn = 4'b0001; tick(8);
    exec(RDA, 8'h00);
    chk("multi_press", bus.btn_state, 4'b0001);
    btn = 4'b0000; tick(10);

    // Press event lands on the same edge as RDA (7th edge after raw change)
    btn = 4'b0100; tick(6);
    exec(RDA, 8'h00);
    chk("coincident_rda", bus.btn_state, 4'b0000);
    exec(RDA, 8'h00);
    chk("coincident_next", bus.btn_state, 4'b0100);
    btn = 4'b0000; tick(10);

    // Selective read then full read
    btn = 4'b1111; tick(10);
    exec(RDC, 8'h02);
    chk("rdc_ch2", bus.btn_state, 4'b0100);
    exec(RDA, 8'h00);
    chk("rda_rest", bus.btn_state, 4'b1011);
    btn = 4'b0000; tick(10);

    // Mask to channel 0 only
    exec(MSK, 8'h01);
    btn = 4'b1111; tick(10);
    exec(RDA, 8'h00);
    chk("masked_rda", bus.btn_state, 4'b0001);
    btn = 4'b0000; tick(10);

    // Undefined opcode locks into ERROR; later reads ignored
    chk_err("pre_error", 1'b0);
    bus.inst    = 12'hBAE;
    bus.inst_en = 1'b1;
    tick(1);
    bus.inst_en = 1'b0;
    chk_err("bad_opcode", 1'b1);
    exec(RDA, 8'h00);
    chk("error_frozen", bus.btn_state, 4'b0001);
    chk_err("error_sticky", 1'b1);

    reset = 1'b0; #2;
    chk_err("reset_clears_err", 1'b0);
    chk("reset_clears_state", bus.btn_state, 4'b0000);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Out-of-range channel
    exec(RDC, 8'h05);
    chk_err("rdc_range", 1'b1);
    chk("rdc_range_state", bus.btn_state, 4'b0000);

    reset = 1'b0; tick(1);
    reset = 1'b1; tick(1);
    chk_err("reset2_error", 1'b0);
    exec(RDA, 8'h00);
    chk("post_reset_rda", bus.btn_state, 4'b0000);

    // Mask returns to all ones after reset
    btn = 4'b1000; tick(10);
    exec(RDA, 8'h00);
    chk("mask_reset", bus.btn_state, 4'b1000);
    btn = 4'b0000; tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
